// File: rtl/adder_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle through a registered carry,
// with valid/ready handshakes on both the operand and the result side.
module adder_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             v_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, work_reg, s_reg;
  logic             carry_reg, sub_reg, c_reg, v_reg;
  logic [CW-1:0]    cnt_reg;

  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic [WIDTH-1:0] merged;
  logic             carry_out, msb_carry_in, last_chunk, accept;

  assign ready_o    = (state_reg == IDLE);
  assign valid_o    = (state_reg == DONE);
  assign s_o        = s_reg;
  assign c_o        = c_reg;
  assign v_o        = v_reg;
  assign accept     = valid_i && ready_o;
  assign last_chunk = (cnt_reg == LAST_CHUNK);

  // Operand chunk select for the current counter value
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_reg == CW'(i)) begin
        a_chunk = a_reg[i*CHUNK +: CHUNK];
        b_chunk = b_reg[i*CHUNK +: CHUNK];
      end
    end
  end

  assign {carry_out, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};

  // Working result with the current chunk's sum dropped into place
  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_merge
      assign merged[gi*CHUNK +: CHUNK] = (cnt_reg == CW'(gi)) ? sum_chunk
                                                              : work_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out without another adder
  assign msb_carry_in = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ merged[WIDTH-1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (valid_i) state_next = CALC;
      CALC:    if (last_chunk) state_next = DONE;
      DONE:    if (ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_reg     <= '0;
      b_reg     <= '0;
      work_reg  <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      sub_reg   <= 1'b0;
      c_reg     <= 1'b0;
      v_reg     <= 1'b0;
      cnt_reg   <= '0;
    end else if (accept) begin
      a_reg     <= a_i;
      b_reg     <= sub_i ? ~b_i : b_i;
      carry_reg <= sub_i ? ~c_i : c_i;
      sub_reg   <= sub_i;
      cnt_reg   <= '0;
    end else if (state_reg == CALC) begin
      work_reg  <= merged;
      carry_reg <= carry_out;
      if (last_chunk) begin
        s_reg <= merged;
        c_reg <= sub_reg ? ~carry_out : carry_out;
        v_reg <= msb_carry_in ^ carry_out;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_seq.sv
// Directed and randomised checks of adder_seq at CHUNK=4, plus CHUNK=1 and CHUNK=16
// instances run in lockstep on shared inputs.
module tb_adder_seq;

  logic        clk = 1'b0;
  logic        rst, valid_i, ready_i, c_in, sub;
  logic [15:0] a, b;
  logic        rdy4, vld4, co4, vo4;
  logic        rdy1, vld1, co1, vo1;
  logic        rdy16, vld16, co16, vo16;
  logic [15:0] s4, s1, s16;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_seq #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy4), .a_i(a), .b_i(b),
    .c_i(c_in), .sub_i(sub), .valid_o(vld4), .ready_i(ready_i), .s_o(s4), .c_o(co4), .v_o(vo4));

  adder_seq #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy1), .a_i(a), .b_i(b),
    .c_i(c_in), .sub_i(sub), .valid_o(vld1), .ready_i(ready_i), .s_o(s1), .c_o(co1), .v_o(vo1));

  adder_seq #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(rdy16), .a_i(a), .b_i(b),
    .c_i(c_in), .sub_i(sub), .valid_o(vld16), .ready_i(ready_i), .s_o(s16), .c_o(co16), .v_o(vo16));

  typedef struct {
    logic [15:0] a, b;
    logic        c, sub;
    logic [15:0] s;
    logic        co, vo;
  } vec_t;

  // Reference: plain 17-bit arithmetic, signed overflow from operand/result sign bits
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic msub);
    logic [16:0] r;
    logic        v;
    if (!msub) begin
      r = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
      v = (ma[15] == mb[15]) && (r[15] != ma[15]);
    end else begin
      r = {1'b0, ma} - {1'b0, mb} - {16'd0, mc};
      v = (ma[15] != mb[15]) && (r[15] != ma[15]);
    end
    return {v, r[16], r[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic isub);
    a = ia; b = ib; c_in = ic; sub = isub;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_valid4(output int lat);
    lat = 0;
    while (!vld4 && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (rdy4 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", rdy4); end
    checks++; if (vld4 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", vld4); end
    checks++; if (s4 !== 16'h0000) begin failures++; $display("FAIL reset_s got=%h exp=0000", s4); end
    checks++; if ({co4, vo4} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", co4, vo4); end
  endtask

  task automatic test_directed();
    vec_t vecs[8];
    int   lat;
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};
    vecs[2] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sub);
      wait_valid4(lat);
      $display("directed %0d a=%h b=%h c=%b sub=%b -> s=%h c_o=%b v_o=%b lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sub, s4, co4, vo4, lat);
      checks++; if (lat !== 4) begin failures++; $display("FAIL directed_latency[%0d] got=%0d exp=4", i, lat); end
      checks++;
      if ({s4, co4, vo4} !== {vecs[i].s, vecs[i].co, vecs[i].vo}) begin
        failures++;
        $display("FAIL directed_result[%0d] got s=%h c=%b v=%b exp s=%h c=%b v=%b",
                 i, s4, co4, vo4, vecs[i].s, vecs[i].co, vecs[i].vo);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    issue(16'h00F0, 16'h0F0F, 1'b0, 1'b0);
    wait_valid4(lat);
    for (int i = 0; i < 10; i++) begin
      valid_i = i[0];
      a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; sub = 1'b0;
      tick();
      checks++;
      if (vld4 !== 1'b1 || rdy4 !== 1'b0 || s4 !== 16'h0FFF || co4 !== 1'b0 || vo4 !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold[%0d] got valid=%b ready=%b s=%h c=%b v=%b exp valid=1 ready=0 s=0fff c=0 v=0",
                 i, vld4, rdy4, s4, co4, vo4);
      end
    end
    valid_i = 1'b0;
    release_result();
    $display("backpressure a=00f0 b=0f0f -> s=%h after release ready=%b valid=%b", s4, rdy4, vld4);
    checks++;
    if (rdy4 !== 1'b1 || vld4 !== 1'b0 || s4 !== 16'h0FFF) begin
      failures++;
      $display("FAIL backpressure_release got ready=%b valid=%b s=%h exp ready=1 valid=0 s=0fff", rdy4, vld4, s4);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (vld4 !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL backpressure_no_stray got=%0d valid cycles exp=0", bad); end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    issue(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset_mid_calc -> ready=%b valid=%b s=%h c=%b v=%b", rdy4, vld4, s4, co4, vo4);
    checks++;
    if (rdy4 !== 1'b1 || vld4 !== 1'b0 || s4 !== 16'h0000 || co4 !== 1'b0 || vo4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_calc got ready=%b valid=%b s=%h c=%b v=%b exp ready=1 valid=0 s=0000 c=0 v=0",
               rdy4, vld4, s4, co4, vo4);
    end
    issue(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_valid4(lat);
    $display("after_reset a=1234 b=1111 -> s=%h lat=%0d", s4, lat);
    checks++;
    if (lat !== 4 || s4 !== 16'h2345 || co4 !== 1'b0 || vo4 !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_op got s=%h c=%b v=%b lat=%0d exp s=2345 c=0 v=0 lat=4", s4, co4, vo4, lat);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int          lat, waits, acc, prev_acc;
    logic [17:0] exp;
    prev_acc = -1;
    ready_i = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      waits = 0;
      while (!rdy4 && waits < 50) begin
        tick();
        waits++;
      end
      a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      exp = model(a, b, c_in, sub);
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      acc = cyc;
      if (prev_acc >= 0) begin
        checks++;
        if (acc - prev_acc !== 6) begin
          failures++;
          $display("FAIL b2b_interval[%0d] got=%0d exp=6", i, acc - prev_acc);
        end
      end
      prev_acc = acc;
      wait_valid4(lat);
      $display("b2b %0d a=%h b=%h c=%b sub=%b -> s=%h c_o=%b v_o=%b lat=%0d",
               i, a, b, c_in, sub, s4, co4, vo4, lat);
      checks++;
      if (lat !== 4 || {vo4, co4, s4} !== exp) begin
        failures++;
        $display("FAIL b2b_result[%0d] got v=%b c=%b s=%h lat=%0d exp v=%b c=%b s=%h lat=4",
                 i, vo4, co4, s4, lat, exp[17], exp[16], exp[15:0]);
      end
      tick();
    end
    ready_i = 1'b0;
  endtask

  task automatic test_chunk_builds();
    int          l1, l4, l16;
    logic [17:0] exp;
    rst = 1'b1; ready_i = 1'b0; valid_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 24; i++) begin
      if (i == 0)      begin a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; sub = 1'b0; end
      else if (i == 1) begin a = 16'h8000; b = 16'h0001; c_in = 1'b0; sub = 1'b1; end
      else if (i == 2) begin a = 16'h7FFF; b = 16'h0000; c_in = 1'b1; sub = 1'b0; end
      else if (i == 3) begin a = 16'h0005; b = 16'h0003; c_in = 1'b1; sub = 1'b1; end
      else begin
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      end
      exp = model(a, b, c_in, sub);
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      l1 = 0; l4 = 0; l16 = 0;
      for (int n = 1; n <= 20; n++) begin
        tick();
        if (vld1 && l1 == 0) l1 = n;
        if (vld4 && l4 == 0) l4 = n;
        if (vld16 && l16 == 0) l16 = n;
      end
      $display("chunks %0d a=%h b=%h c=%b sub=%b -> s1=%h s4=%h s16=%h lat=%0d/%0d/%0d",
               i, a, b, c_in, sub, s1, s4, s16, l1, l4, l16);
      checks++;
      if (l1 !== 16 || l4 !== 4 || l16 !== 1) begin
        failures++;
        $display("FAIL chunk_latency[%0d] got=%0d/%0d/%0d exp=16/4/1", i, l1, l4, l16);
      end
      checks++;
      if ({vo1, co1, s1} !== exp) begin
        failures++;
        $display("FAIL chunk1_result[%0d] got v=%b c=%b s=%h exp v=%b c=%b s=%h",
                 i, vo1, co1, s1, exp[17], exp[16], exp[15:0]);
      end
      checks++;
      if ({vo16, co16, s16} !== exp) begin
        failures++;
        $display("FAIL chunk16_result[%0d] got v=%b c=%b s=%h exp v=%b c=%b s=%h",
                 i, vo16, co16, s16, exp[17], exp[16], exp[15:0]);
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_chunk_builds();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
